// File: rtl/kpn_pkg.sv
// Shared KPN definitions: token width/type and default channel depth.
// Reused by kpn_fifo_channel, split_module and the other KPN processes.
package kpn_pkg;

    localparam int unsigned KPN_TOKEN_W       = 16;
    localparam int unsigned KPN_DEFAULT_DEPTH = 8;

    typedef logic [KPN_TOKEN_W-1:0] kpn_token_t;

endpackage

// File: rtl/kpn_fifo_mem.sv
// Simple dual-port register array: one synchronous write port and one
// registered read port whose output clears on reset and holds when idle.
module kpn_fifo_mem
    import kpn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = KPN_TOKEN_W,
    parameter int unsigned DEPTH      = KPN_DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/kpn_fifo_channel.sv
// Bounded KPN FIFO channel with Kahn blocking semantics and sticky
// overflow/underflow flags; all outputs are registers or decodes of registers.
module kpn_fifo_channel
    import kpn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = KPN_TOKEN_W,
    parameter int unsigned DEPTH      = KPN_DEFAULT_DEPTH,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned CntW = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]       count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_ok, rd_ok;

    assign full  = (count_q == CntW'(DEPTH));
    assign empty = (count_q == '0);

    // A read frees a slot on the same edge, so a full channel still accepts
    // a write paired with a read. No fall-through on empty.
    always_comb begin
        rd_ok       = rd & ~empty;
        wr_ok       = wr & (~full | rd_ok);
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CntW'(wr_ok) - CntW'(rd_ok);
        overflow_d  = overflow_q | (wr & ~wr_ok);
        underflow_d = underflow_q | (rd & ~rd_ok);
        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (rd_ok) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    kpn_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok & ~rst),
        .waddr (wr_ptr_q),
        .wdata (data_in),
        .re    (rd_ok & ~rst),
        .raddr (rd_ptr_q),
        .rdata (data_out)
    );

    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_kpn_fifo_channel.sv
// Directed self-checking bench for kpn_fifo_channel (DEPTH=8, 16-bit tokens).
module tb_kpn_fifo_channel;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_in = '0;
    logic [15:0] data_out;
    logic        full, empty, overflow, underflow;
    logic [3:0]  count;

    int tests = 0;
    int fails = 0;

    kpn_fifo_channel #(
        .DATA_WIDTH (16),
        .DEPTH      (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .data_in   (data_in),
        .rd        (rd),
        .data_out  (data_out),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full status check; empty/full are derived from the expected count.
    task automatic chk_state(input string tag, input int exp_cnt, input logic [15:0] exp_dout,
                             input logic exp_ov, input logic exp_un);
        chk({tag, ".count"}, 32'(count), 32'(exp_cnt));
        chk({tag, ".empty"}, 32'(empty), 32'(exp_cnt == 0));
        chk({tag, ".full"}, 32'(full), 32'(exp_cnt == 8));
        chk({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        chk({tag, ".overflow"}, 32'(overflow), 32'(exp_ov));
        chk({tag, ".underflow"}, 32'(underflow), 32'(exp_un));
    endtask

    // One clock: drive strobes, step past the edge, then release them.
    task automatic cyc(input logic w, input logic [15:0] d, input logic r);
        wr      = w;
        data_in = d;
        rd      = r;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    initial begin
        // Reset then idle
        cyc(1'b0, 16'h0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 16'h0, 1'b0);
            chk_state("idle", 0, 16'h0000, 1'b0, 1'b0);
        end

        // Fill 0x0001..0x0008
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 16'(i), 1'b0);
            chk("fill.count", 32'(count), 32'(i));
        end
        chk_state("filled", 8, 16'h0000, 1'b0, 1'b0);

        // Drain: each token appears one cycle after its rd
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("drain.data", 32'(data_out), 32'(i));
            chk("drain.count", 32'(count), 32'(8 - i));
        end
        chk_state("drained", 0, 16'h0008, 1'b0, 1'b0);

        // Wrap-around: pointers move to 6, then 0x00A0..0x00A5 straddle the wrap
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h0100 + 16'(i), 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("pre_wrap.data", 32'(data_out), 32'(16'h0100 + 16'(i)));
        end
        for (int i = 0; i < 6; i++) cyc(1'b1, 16'h00A0 + 16'(i), 1'b0);
        chk("wrap.count", 32'(count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("wrap.data", 32'(data_out), 32'(16'h00A0 + 16'(i)));
        end
        chk_state("wrapped", 0, 16'h00A5, 1'b0, 1'b0);

        // Overflow: full of 0x0011..0x0018, write 0xBEEF without read
        for (int i = 0; i < 8; i++) cyc(1'b1, 16'h0011 + 16'(i), 1'b0);
        cyc(1'b1, 16'hBEEF, 1'b0);
        chk_state("overflow", 8, 16'h00A5, 1'b1, 1'b0);

        // Full with rd & wr: both accepted, no new overflow cause
        cyc(1'b1, 16'h1234, 1'b1);
        chk_state("full_rdwr", 8, 16'h0011, 1'b1, 1'b0);
        for (int i = 1; i < 8; i++) begin
            cyc(1'b0, 16'h0, 1'b1);
            chk("ovf_drain.data", 32'(data_out), 32'(16'h0011 + 16'(i)));
        end
        cyc(1'b0, 16'h0, 1'b1);
        chk_state("last_1234", 0, 16'h1234, 1'b1, 1'b0);

        // Empty with rd & wr: write accepted, read rejected
        cyc(1'b1, 16'h5555, 1'b1);
        chk_state("empty_rdwr", 1, 16'h1234, 1'b1, 1'b1);
        cyc(1'b0, 16'h0, 1'b1);
        chk_state("read_5555", 0, 16'h5555, 1'b1, 1'b1);

        // Reset mid-operation with count=5 and wr & rd asserted
        for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0200 + 16'(i), 1'b0);
        chk("pre_rst.count", 32'(count), 32'd5);
        rst = 1'b1;
        cyc(1'b1, 16'h9999, 1'b1);
        rst = 1'b0;
        chk_state("mid_rst", 0, 16'h0000, 1'b0, 1'b0);

        // Channel is usable after reset and the reset-cycle write was dropped
        cyc(1'b1, 16'h7777, 1'b0);
        chk("post_rst.count", 32'(count), 32'd1);
        cyc(1'b0, 16'h0, 1'b1);
        chk_state("post_rst", 0, 16'h7777, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/kpn_fifo_channel.md
Name: kpn_fifo_channel

Overview:
- Bounded FIFO channel that carries 16-bit tokens between KPN processes.
- Sits directly upstream of split_module: its data_out drives split entry_1, and the split rd strobe drives this block's rd.
- Gives the network Kahn blocking semantics. Writers stall on full, readers stall on empty.
- Sticky error flags report any protocol violation.

Parameters:
- DATA_WIDTH, 16, token width in bits.
- DEPTH, 8, number of token slots. Must be a power of two and at least 2.
- ADDR_WIDTH, clog2(DEPTH), localparam for the pointer index width. Not overridable.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- wr  input  1  write strobe from the producer; sampled each posedge.
- data_in  input  DATA_WIDTH  token to enqueue when wr=1.
- rd  input  1  read strobe from the consumer (split_module rd); sampled each posedge.
- data_out  output  DATA_WIDTH  registered head token, valid the cycle after an accepted read.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  ADDR_WIDTH+1  number of tokens currently stored.
- overflow  output  1  sticky; set by a rejected write.
- underflow  output  1  sticky; set by a rejected read.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- Reset: clears wr_ptr, rd_ptr and count to 0, and clears data_out, overflow and underflow to 0.
  - After reset, empty=1 and full=0.
  - Storage array contents are not reset.
  - Reset mid-operation discards all stored tokens on that edge; any wr or rd in the same cycle is ignored.
- Write acceptance: wr_ok = wr & (~full | rd_ok).
  - On wr_ok, data_in is stored at mem[wr_ptr] and wr_ptr increments, wrapping from DEPTH-1 to 0.
- Read acceptance: rd_ok = rd & ~empty.
  - On rd_ok, data_out <= mem[rd_ptr] and rd_ptr increments, wrapping from DEPTH-1 to 0.
  - Read latency is 1 cycle.
  - data_out holds its last value when no read is accepted.
- No fall-through: a token written in cycle N is readable no earlier than cycle N+1.
  - When empty and wr & rd arrive together, the write is accepted, the read is rejected, underflow is set, and count becomes 1.
- Full and simultaneous rd & wr: both are accepted, count is unchanged, and no overflow is flagged.
- Count update: count <= count + wr_ok - rd_ok. full and empty are decoded combinationally from count.
- Errors:
  - wr while full with no accepted read sets overflow. The token is dropped and the pointers are unchanged.
  - rd while empty sets underflow and data_out is unchanged.
  - Both flags stay set until rst.
- Pointers are ADDR_WIDTH bits with natural wrap. count disambiguates full from empty.
- No combinational path from wr or rd to full, empty or count. All outputs are registers or decodes of registers.

Decomposition:
- Shared package kpn_pkg holds:
  - KPN_TOKEN_W = 16 and typedef kpn_token_t, reused by split_module and the other KPN processes.
  - KPN_DEFAULT_DEPTH = 8.
- One natural sub-module, kpn_fifo_mem: a simple dual-port register array with DEPTH entries, one synchronous write port and one registered read port.
  - Pointer, count and flag logic stay in kpn_fifo_channel.

Test Plan:
- Reset then idle: after rst, empty=1, full=0, count=0, data_out=0, overflow=0 and underflow=0 for 5 cycles.
- Fill and drain, DEPTH=8:
  - Write 0x0001..0x0008 on consecutive cycles. count climbs 1..8 and full=1 after the 8th edge.
  - Then read 8 times. data_out shows 0x0001..0x0008, each one cycle after its rd.
  - Finish with empty=1 and no flags set.
- Wrap-around:
  - Write 6 tokens and read 6, then write 0x00A0..0x00A5 and read them.
  - Order is preserved across the pointer wrap and count returns to 0.
- Overflow: with the channel full of 0x0011..0x0018, assert wr with data_in=0xBEEF and rd=0.
  - overflow=1, count stays 8.
  - A subsequent drain returns 0x0011..0x0018 and 0xBEEF never appears.
- Simultaneous events:
  - Full with rd & wr (data 0x1234): count stays 8, data_out=0x0011, and 0x1234 emerges last.
  - Empty with rd & wr (0x5555): count=1, underflow=1, and 0x5555 is read on the next rd.
- Reset mid-operation: with count=5, assert rst together with wr=1 and rd=1.
  - Next cycle shows count=0, empty=1, data_out=0 and both flags cleared.
